// File: rtl/dcache_port_arbiter_pkg.sv
// Shared data-cache port types: FSM state encoding and the cache request payload.
// Width macros default here when no constants header has defined them first.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ROB_SEL
`define ROB_SEL 6
`endif

package dcache_port_arbiter_pkg;

  localparam int DMEM_ADDR_W = `ADDR_WIDTH;
  localparam int DMEM_DATA_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  typedef struct packed {
    logic                       we;
    logic [DMEM_ADDR_W-1:0]     addr;
    logic [DMEM_DATA_W-1:0]     wdata;
    logic [DMEM_DATA_W/8-1:0]   wmask;
  } dmem_req_t;

endpackage

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single data-cache port between load issue and store commit, one
// transaction outstanding; stores win after STARVE_LIMIT consecutive load grants.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_SEL      = `ROB_SEL,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_req_valid,
  input  logic [ADDR_WIDTH-1:0]   ld_req_addr,
  input  logic [ROB_SEL-1:0]      ld_req_rob,
  output logic                    ld_req_ready,
  input  logic                    st_req_valid,
  input  logic [ADDR_WIDTH-1:0]   st_req_addr,
  input  logic [DATA_WIDTH-1:0]   st_req_data,
  input  logic [DATA_WIDTH/8-1:0] st_req_mask,
  input  logic                    st_urgent,
  output logic                    st_req_ready,
  input  logic                    flush,
  output logic                    mem_req_valid,
  output logic                    mem_req_we,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_rdata,
  output logic                    ld_wb_valid,
  output logic [ROB_SEL-1:0]      ld_wb_rob,
  output logic [DATA_WIDTH-1:0]   ld_wb_data,
  output logic                    busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  logic [1:0]         state;
  logic [SW-1:0]      streak;
  logic               drop;
  dmem_req_t          req;
  logic [ROB_SEL-1:0] rob_q;

  logic in_idle;
  logic ld_pref;
  logic grant_st;
  logic grant_ld;

  // Store wins when urgent, when loads have starved it, or when no load can go.
  always_comb begin
    in_idle  = (state == S_IDLE) && !reset;
    ld_pref  = ld_req_valid && !flush;
    grant_st = in_idle && st_req_valid &&
               (st_urgent || (streak == STREAK_MAX) || !ld_pref);
    grant_ld = in_idle && ld_pref && !grant_st;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      streak      <= '0;
      drop        <= 1'b0;
      req         <= '0;
      rob_q       <= '0;
      ld_wb_valid <= 1'b0;
      ld_wb_rob   <= '0;
      ld_wb_data  <= '0;
    end else begin
      ld_wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_st) begin
            req.we    <= 1'b1;
            req.addr  <= st_req_addr;
            req.wdata <= st_req_data;
            req.wmask <= st_req_mask;
            streak    <= '0;
            state     <= S_REQ;
          end else if (grant_ld) begin
            req.we    <= 1'b0;
            req.addr  <= ld_req_addr;
            req.wdata <= '0;
            req.wmask <= '0;
            rob_q     <= ld_req_rob;
            if (st_req_valid && (streak != STREAK_MAX))
              streak <= streak + SW'(1);
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush && !req.we)
            drop <= 1'b1;
          if (mem_req_ready)
            state <= req.we ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            state <= S_IDLE;
            drop  <= 1'b0;
            // A flush coinciding with the response kills it just like an earlier one.
            if (!drop && !flush) begin
              ld_wb_valid <= 1'b1;
              ld_wb_rob   <= rob_q;
              ld_wb_data  <= mem_resp_rdata;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ld_req_ready  = grant_ld;
  assign st_req_ready  = grant_st;
  assign mem_req_valid = (state == S_REQ);
  assign mem_req_we    = req.we;
  assign mem_req_addr  = req.addr;
  assign mem_req_wdata = req.wdata;
  assign mem_req_wmask = req.wmask;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: inputs change 1ns after posedge,
// outputs are compared at negedge against hand-computed values.
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req_valid;
  logic [31:0] ld_req_addr;
  logic [5:0]  ld_req_rob;
  logic        ld_req_ready;
  logic        st_req_valid;
  logic [31:0] st_req_addr;
  logic [31:0] st_req_data;
  logic [3:0]  st_req_mask;
  logic        st_urgent;
  logic        st_req_ready;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        ld_wb_valid;
  logic [5:0]  ld_wb_rob;
  logic [31:0] ld_wb_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter dut (
    .clk(clk), .reset(reset),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_rob(ld_req_rob),
    .ld_req_ready(ld_req_ready),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_mask(st_req_mask), .st_urgent(st_urgent), .st_req_ready(st_req_ready),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .ld_wb_valid(ld_wb_valid), .ld_wb_rob(ld_wb_rob), .ld_wb_data(ld_wb_data),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    ld_req_valid = 1'b1; ld_req_addr = '0; ld_req_rob = '0;
    st_req_valid = 1'b0; st_req_addr = '0; st_req_data = '0; st_req_mask = '0;
    st_urgent = 1'b0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;

    // Reset state, with a load request present that must not be accepted
    repeat (2) @(posedge clk);
    #1;
    sample();
    check("rst_ld_ready", ld_req_ready, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_wb_valid", ld_wb_valid, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_wb_rob", ld_wb_rob, 0);
    next_cycle();
    reset = 1'b0; ld_req_valid = 1'b0;
    next_cycle();

    // Lone load: grant at 1, request at 2, response at 4, writeback at 5
    ld_req_valid = 1'b1; ld_req_addr = 32'h100; ld_req_rob = 6'd5;
    sample();
    check("ld1_ready", ld_req_ready, 1);
    check("ld1_st_ready", st_req_ready, 0);
    next_cycle();
    ld_req_valid = 1'b0; mem_req_ready = 1'b1;
    sample();
    check("ld1_req_valid", mem_req_valid, 1);
    check("ld1_req_we", mem_req_we, 0);
    check("ld1_req_addr", mem_req_addr, 32'h100);
    check("ld1_req_mask", mem_req_wmask, 0);
    next_cycle();
    mem_req_ready = 1'b0;
    sample();
    check("ld1_wait_valid", mem_req_valid, 0);
    check("ld1_wait_busy", busy, 1);
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEADBEEF;
    sample();
    check("ld1_wb_early", ld_wb_valid, 0);
    next_cycle();
    mem_resp_valid = 1'b0;
    sample();
    check("ld1_wb_valid", ld_wb_valid, 1);
    check("ld1_wb_rob", ld_wb_rob, 5);
    check("ld1_wb_data", ld_wb_data, 32'hDEADBEEF);
    check("ld1_idle", busy, 0);
    next_cycle();
    sample();
    check("ld1_wb_pulse", ld_wb_valid, 0);
    next_cycle();

    // Store held off for three cycles by the cache
    st_req_valid = 1'b1; st_req_addr = 32'h200; st_req_data = 32'h12345678; st_req_mask = 4'hF;
    sample();
    check("st_ready", st_req_ready, 1);
    next_cycle();
    st_req_valid = 1'b0; st_req_addr = 32'h0; st_req_data = 32'h0; st_req_mask = 4'h0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      sample();
      check($sformatf("st_hold_valid%0d", i), mem_req_valid, 1);
      check($sformatf("st_hold_we%0d", i), mem_req_we, 1);
      check($sformatf("st_hold_addr%0d", i), mem_req_addr, 32'h200);
      check($sformatf("st_hold_data%0d", i), mem_req_wdata, 32'h12345678);
      check($sformatf("st_hold_mask%0d", i), mem_req_wmask, 4'hF);
      check($sformatf("st_hold_ready%0d", i), st_req_ready, 0);
      next_cycle();
    end
    mem_req_ready = 1'b0;
    sample();
    check("st_done_busy", busy, 0);
    check("st_done_valid", mem_req_valid, 0);
    check("st_no_wb", ld_wb_valid, 0);
    next_cycle();

    // Starvation guard: store pending behind a continuous load stream
    st_req_valid = 1'b1; st_req_addr = 32'h280; st_req_data = 32'hA5A5A5A5; st_req_mask = 4'h3;
    for (int i = 0; i < 4; i++) begin
      ld_req_valid = 1'b1; ld_req_addr = 32'h1000 + 32'(i * 4); ld_req_rob = 6'(20 + i);
      sample();
      if (i > 0) begin
        check($sformatf("stv_wb_valid%0d", i - 1), ld_wb_valid, 1);
        check($sformatf("stv_wb_rob%0d", i - 1), ld_wb_rob, 32'(20 + i - 1));
      end
      check($sformatf("stv_ld_ready%0d", i), ld_req_ready, 1);
      check($sformatf("stv_st_ready%0d", i), st_req_ready, 0);
      next_cycle();
      mem_req_ready = 1'b1;
      next_cycle();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'(i);
      next_cycle();
      mem_resp_valid = 1'b0;
    end
    sample();
    check("stv_wb_data3", ld_wb_data, 3);
    check("stv_streak_full", dut.streak, 4);
    check("stv_st_ready", st_req_ready, 1);
    check("stv_ld_ready", ld_req_ready, 0);
    next_cycle();
    ld_req_valid = 1'b0; st_req_valid = 1'b0; mem_req_ready = 1'b1;
    sample();
    check("stv_streak_clr", dut.streak, 0);
    check("stv_req_we", mem_req_we, 1);
    check("stv_req_addr", mem_req_addr, 32'h280);
    next_cycle();
    mem_req_ready = 1'b0;

    // Urgent store beats a valid load
    ld_req_valid = 1'b1; st_req_valid = 1'b1; st_urgent = 1'b1; st_req_addr = 32'h2C0;
    sample();
    check("urg_st_ready", st_req_ready, 1);
    check("urg_ld_ready", ld_req_ready, 0);
    next_cycle();
    ld_req_valid = 1'b0; st_req_valid = 1'b0; st_urgent = 1'b0; mem_req_ready = 1'b1;
    sample();
    check("urg_req_we", mem_req_we, 1);
    next_cycle();
    mem_req_ready = 1'b0;

    // Flush in IDLE only blocks the load grant that cycle
    ld_req_valid = 1'b1; ld_req_addr = 32'h300; ld_req_rob = 6'd9; flush = 1'b1;
    sample();
    check("fidle_ld_ready", ld_req_ready, 0);
    next_cycle();
    flush = 1'b0;
    sample();
    check("fidle_busy", busy, 0);
    check("fl_ld_ready", ld_req_ready, 1);
    next_cycle();

    // Flush while waiting for rob 9's response
    ld_req_valid = 1'b0; mem_req_ready = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0; flush = 1'b1;
    sample();
    check("fl_wait_busy", busy, 1);
    next_cycle();
    flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h00000BAD;
    next_cycle();
    mem_resp_valid = 1'b0;
    ld_req_valid = 1'b1; ld_req_addr = 32'h304; ld_req_rob = 6'd10;
    sample();
    check("fl_no_wb", ld_wb_valid, 0);
    check("fl_wb_hold", ld_wb_data, 3);
    check("fl_idle", busy, 0);
    check("fl_next_ready", ld_req_ready, 1);
    next_cycle();
    ld_req_valid = 1'b0; mem_req_ready = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFEF00D;
    next_cycle();
    mem_resp_valid = 1'b0;
    sample();
    check("fl2_wb_valid", ld_wb_valid, 1);
    check("fl2_wb_rob", ld_wb_rob, 10);
    check("fl2_wb_data", ld_wb_data, 32'hCAFEF00D);
    next_cycle();

    // Reset while the request is outstanding
    ld_req_valid = 1'b1; ld_req_addr = 32'h400; ld_req_rob = 6'd3;
    next_cycle();
    ld_req_valid = 1'b0;
    sample();
    check("rreq_valid", mem_req_valid, 1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    sample();
    check("rreq_valid_after", mem_req_valid, 0);
    check("rreq_busy_after", busy, 0);
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55555555;
    next_cycle();
    mem_resp_valid = 1'b0;
    sample();
    check("stray_no_wb", ld_wb_valid, 0);
    check("stray_busy", busy, 0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single data-cache port between load-queue issue and store-buffer commit.
- Grants one requester per transaction and drives a valid/ready request onto the cache port.
- For loads, waits for the read response and returns the data with its ROB index to writeback.
- One transaction is outstanding at a time. Stores have a starvation guard against a continuous load stream.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH (32), address width.
- DATA_WIDTH, 32, data width.
- ROB_SEL, `ROB_SEL (6), ROB index width.
- STARVE_LIMIT, 4, maximum consecutive load grants while a store waits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ld_req_valid  in  1  load queue has a ready load
- ld_req_addr  in  ADDR_WIDTH  load address
- ld_req_rob  in  ROB_SEL  load ROB index
- ld_req_ready  out  1  load accepted this cycle (combinational)
- st_req_valid  in  1  store buffer head ready to commit
- st_req_addr  in  ADDR_WIDTH  store address
- st_req_data  in  DATA_WIDTH  store data
- st_req_mask  in  DATA_WIDTH/8  byte enables
- st_urgent  in  1  store buffer almost full
- st_req_ready  out  1  store accepted this cycle (combinational)
- flush  in  1  pipeline flush; kills in-flight load result
- mem_req_valid  out  1  cache request valid
- mem_req_we  out  1  1 = store
- mem_req_addr  out  ADDR_WIDTH  registered address
- mem_req_wdata  out  DATA_WIDTH  registered store data
- mem_req_wmask  out  DATA_WIDTH/8  registered byte enables (0 for loads)
- mem_req_ready  in  1  cache accepts request
- mem_resp_valid  in  1  load data valid
- mem_resp_rdata  in  DATA_WIDTH  load data
- ld_wb_valid  out  1  one-cycle writeback pulse
- ld_wb_rob  out  ROB_SEL  writeback ROB index
- ld_wb_data  out  DATA_WIDTH  writeback data
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high, all clk edges):
  - state = IDLE; streak = 0; drop = 0.
  - All outputs 0, including mem_req_* registers and ld_wb_*.
  - Reset mid-transaction abandons the transaction with no writeback.
- States:
  - IDLE: grant possible.
  - REQ: mem_req_valid = 1, payload held stable.
  - WAIT: load issued, awaiting response.
- Grant, IDLE only (ld_req_ready and st_req_ready are 0 in REQ and WAIT, at most one asserted):
  - Priority 1: st_urgent && st_req_valid grants the store.
  - Priority 2: st_req_valid && streak == STARVE_LIMIT grants the store.
  - Priority 3: ld_req_valid && !flush grants the load.
  - Priority 4: st_req_valid grants the store.
  - Grant latches the payload and the load ROB index. The next state is REQ.
- Streak counter:
  - Increments, saturating at STARVE_LIMIT, on a load grant while st_req_valid = 1.
  - Clears on a store grant.
  - Unchanged otherwise.
- Latency: grant at cycle N gives mem_req_valid at N+1.
- REQ:
  - mem_req_valid holds with a stable payload until mem_req_ready is sampled high; it is never retracted.
  - On acceptance, a store goes to IDLE. The store is complete and gets no response.
  - On acceptance, a load goes to WAIT. mem_req_valid drops the same edge.
- WAIT:
  - On mem_resp_valid, the next state is IDLE.
  - If drop == 0 and flush == 0, ld_wb_valid = 1 the next cycle with the latched ROB index and the registered rdata.
  - Otherwise the response is silently consumed.
  - drop clears on exit.
- Flush:
  - In REQ with a load, or in WAIT, flush sets drop.
  - flush has no effect on stores.
  - flush in IDLE blocks only a load grant that cycle.
- Stray input: mem_resp_valid outside WAIT is ignored.
- Back-to-back: a response at cycle M returns to IDLE at M+1, so the next grant can be at M+1.
- ld_wb_valid is a single-cycle pulse. ld_wb_rob/ld_wb_data hold their last values otherwise.

Decomposition:
- Shared package: state enum (IDLE/REQ/WAIT) and a dmem_req struct {we, addr, wdata, wmask}, reused by the future cache and store buffer.
- Widths come from constants.vh macros.
- No sub-module. Arbitration plus streak counter is a small inline block.

Test Plan:
- Lone load: ld_req_valid, addr 0x100, rob 5 at cycle 1.
  -> ld_req_ready at 1; mem_req_valid, we = 0 at 2.
  -> With mem_req_ready at 2 and mem_resp_valid data 0xDEADBEEF at 4: ld_wb_valid, rob 5, data 0xDEADBEEF at 5.
- Store with backpressure: store addr 0x200, data 0x12345678, mask 0xF; mem_req_ready low for 3 cycles.
  -> mem_req_valid held 4 cycles, payload unchanged; IDLE the cycle after acceptance; no ld_wb_valid.
- Starvation: loads continuous with a store pending, STARVE_LIMIT = 4.
  -> Four load grants, then the store is granted; streak back to 0.
- Urgent: st_urgent = 1 with both requesters valid in IDLE.
  -> st_req_ready = 1, ld_req_ready = 0.
- Flush in WAIT: flush asserted one cycle while awaiting the response of rob 9.
  -> Response consumed, no ld_wb_valid; next load is granted normally and written back.
- Reset in REQ: reset asserted while mem_req_valid = 1.
  -> Next cycle: mem_req_valid = 0, busy = 0; a later stray mem_resp_valid produces no writeback.
